// File: rtl/mem_burst_pkg.sv
// mem_burst_pkg: shared types and constants for the burst controller slice.
// FSM state encodings, command opcode encoding and read-buffer depth.
package mem_burst_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam int RDBUF_DEPTH = 2;

endpackage

// File: rtl/mem_burst_rdbuf.sv
// mem_burst_rdbuf: 2-entry synchronous FIFO that catches RAM read data.
// Push and pop may happen in the same cycle; head reads as zero when empty.
module mem_burst_rdbuf
  import mem_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] slots [RDBUF_DEPTH];
  logic                  rd_ptr;
  logic                  wr_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Ignore pushes into a full buffer and pops from an empty one.
  always_comb begin
    do_pop  = pop && (count != 2'd0);
    do_push = push && ((count != 2'd2) || do_pop);
  end

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slots[0] <= '0;
      slots[1] <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (do_push) begin
        slots[wr_ptr] <= push_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = (count == 2'd0) ? '0 : slots[rd_ptr];

endmodule

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: burst initiator for a single-port RAM with 1-cycle read latency.
// Config macro MEM_BURST_WRAP_EN: defined = bursts wrap past the top address and
// err is never raised; undefined = out-of-range commands are rejected with err.
module mem_burst_ctrl
  import mem_burst_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic                  mem_ren,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // Raw state encodings, kept as plain constants for legacy comparisons.
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_WRITE = WRITE;
  localparam logic [1:0] ST_READ  = READ;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] beats_left;
  logic                  inflight;
  logic                  done_q;
  logic                  err_q;

  logic                  cmd_fire;
  logic                  wr_fire;
  logic                  pop;
  logic                  last_beat;
  logic                  range_bad;
  logic [1:0]            fifo_count;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [2:0]            occupancy;

`ifdef MEM_BURST_WRAP_EN
  // Wrapping bursts are always legal.
  assign range_bad = 1'b0;
`else
  logic [ADDR_WIDTH:0] end_addr;

  // A carry out of start+len means the burst would run past the top address.
  always_comb begin
    end_addr  = {1'b0, cmd_addr} + {1'b0, cmd_len};
    range_bad = end_addr[ADDR_WIDTH];
  end
`endif

  // Handshakes and RAM port drive; read issue is throttled so that buffered
  // plus in-flight beats never exceed the two buffer slots.
  always_comb begin
    cmd_ready = (state == ST_IDLE);
    cmd_fire  = cmd_valid && cmd_ready;
    wr_ready  = (state == ST_WRITE);
    wr_fire   = wr_valid && wr_ready;
    rd_valid  = (fifo_count != 2'd0);
    rd_data   = fifo_head;
    pop       = rd_valid && rd_ready;
    last_beat = (beats_left == '0);
    occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    mem_wen   = wr_fire;
    mem_ren   = (state == ST_READ) && (occupancy < 3'd2);
    mem_addr  = ((state == ST_WRITE) || (state == ST_READ)) ? cur_addr : '0;
    mem_wdata = (state == ST_WRITE) ? wr_data : '0;
    done      = done_q;
    err       = err_q;
  end

  // Burst sequencing: command latch, beat counting, completion and reject pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cur_addr   <= '0;
      beats_left <= '0;
      inflight   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      inflight <= mem_ren;
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            if (range_bad) begin
              err_q <= 1'b1;
            end else begin
              cur_addr   <= cmd_addr;
              beats_left <= cmd_len;
              state      <= (cmd_write == OP_WRITE) ? ST_WRITE : ST_READ;
            end
          end
        end
        ST_WRITE: begin
          if (wr_fire) begin
            cur_addr   <= cur_addr + ADDR_ONE;
            beats_left <= beats_left - ADDR_ONE;
            if (last_beat) begin
              state  <= ST_IDLE;
              done_q <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (mem_ren) begin
            cur_addr   <= cur_addr + ADDR_ONE;
            beats_left <= beats_left - ADDR_ONE;
            if (last_beat) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!inflight && (fifo_count == 2'd1) && pop) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mem_burst_rdbuf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rdbuf (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .pop      (pop),
    .push_data(mem_rdata),
    .count    (fifo_count),
    .head     (fifo_head)
  );

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl: table-driven bench for mem_burst_ctrl with a behavioural RAM.
// Honours MEM_BURST_WRAP_EN to pick wrap or reject expectations.
module tb_mem_burst_ctrl;

`ifdef MEM_BURST_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [3:0] cmd_addr;
  logic [3:0] cmd_len;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [7:0] rd_data;
  logic       done;
  logic       err;
  logic [3:0] mem_addr;
  logic       mem_wen;
  logic       mem_ren;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  mem_burst_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .err(err),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_ren(mem_ren),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM with registered read.
  logic [7:0] ram [16];
  always @(posedge clk) begin
    if (mem_wen) ram[mem_addr] <= mem_wdata;
    if (mem_ren) mem_rdata <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log gathered mid-cycle, away from the active edge.
  logic [3:0] wenAddr[$];
  logic [7:0] wenData[$];
  logic [3:0] renAddr[$];
  logic [7:0] rdOut[$];
  int doneCount, errCount, doneCycle, errCycle, firstRvCycle;
  int issued, popped, maxOut, bothHigh;

  always @(negedge clk) begin
    if (mem_wen) begin
      wenAddr.push_back(mem_addr);
      wenData.push_back(mem_wdata);
    end
    if (mem_ren) begin
      renAddr.push_back(mem_addr);
      issued++;
    end
    if (mem_wen && mem_ren) bothHigh++;
    if (rd_valid && firstRvCycle < 0) firstRvCycle = cyc;
    if (rd_valid && rd_ready) begin
      rdOut.push_back(rd_data);
      popped++;
    end
    if (done) begin
      doneCount++;
      doneCycle = cyc;
    end
    if (err) begin
      errCount++;
      errCycle = cyc;
    end
    if (issued - popped > maxOut) maxOut = issued - popped;
  end

  int checks = 0;
  int failures = 0;
  logic [7:0] shadow [16];
  int hsCycle;

  typedef struct {
    bit         isWrite;
    logic [3:0] addr;
    logic [3:0] len;
    logic [7:0] base;
    bit         expErr;
    int         expAcc;
    int         expDone;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [7:0] beatData(input logic [7:0] base, input int i);
    return base + 8'(i) * 8'h11;
  endfunction

  task automatic clearLog();
    wenAddr.delete(); wenData.delete(); renAddr.delete(); rdOut.delete();
    doneCount = 0; errCount = 0; doneCycle = -1; errCycle = -1; firstRvCycle = -1;
    issued = 0; popped = 0; maxOut = 0; bothHigh = 0;
  endtask

  task automatic sendCmd(input bit w, input logic [3:0] a, input logic [3:0] l);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    hsCycle = cyc;
    @(negedge clk);
    checkOutput("cmd_ready_at_issue", int'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Drive write beats; bit g of gapMask holds wr_valid low in drive cycle g.
  task automatic applyStimulus(input int len, input logic [7:0] base, input logic [15:0] gapMask);
    int beat = 0;
    int guard = 0;
    bit acc;
    while (beat <= len && guard < 64) begin
      wr_valid = !gapMask[guard % 16];
      wr_data  = beatData(base, beat);
      @(negedge clk);
      acc = wr_valid && wr_ready;
      @(posedge clk); #1;
      if (acc) beat++;
      guard++;
    end
    wr_valid = 1'b0;
    checkOutput("wr_beats_accepted", beat, len + 1);
  endtask

  task automatic waitEnd(input string name);
    bit ended = 1'b0;
    for (int t = 0; t < 80; t++) begin
      if (doneCount > 0 || errCount > 0) begin
        ended = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    checkOutput(name, int'(ended), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic runVector(input int idx);
    vec_t v = vecs[idx];
    int bad = 0;
    int n = v.expAcc;
    clearLog();
    rd_ready = !v.isWrite;
    sendCmd(v.isWrite, v.addr, v.len);
    if (v.isWrite && !v.expErr) applyStimulus(int'(v.len), v.base, 16'h0000);
    if (v.expErr) repeat (int'(v.len) + 3) @(posedge clk);
    #1;
    if (!v.expErr) waitEnd("burst_end");
    rd_ready = 1'b0;
    checkOutput("err_count", errCount, int'(v.expErr));
    checkOutput("done_count", doneCount, v.expDone);
    checkOutput("wen_count", wenAddr.size(), v.isWrite ? n : 0);
    checkOutput("ren_count", renAddr.size(), v.isWrite ? 0 : n);
    checkOutput("wen_ren_overlap", bothHigh, 0);
    if (v.expErr) checkOutput("err_latency", errCycle - hsCycle, 1);
    for (int i = 0; i < n; i++) begin
      logic [3:0] ea = v.addr + 4'(i);
      if (v.isWrite) begin
        if (i < wenAddr.size()) begin
          if (wenAddr[i] !== ea || wenData[i] !== beatData(v.base, i)) bad++;
        end
        shadow[ea] = beatData(v.base, i);
      end else begin
        if (i < renAddr.size() && renAddr[i] !== ea) bad++;
        if (i < rdOut.size() && rdOut[i] !== shadow[ea]) bad++;
      end
    end
    checkOutput("access_seq_errors", bad, 0);
    if (!v.isWrite) checkOutput("rd_beats_out", rdOut.size(), n);
    if (!v.expErr && v.isWrite) checkOutput("wr_done_latency", doneCycle - hsCycle, int'(v.len) + 2);
    if (!v.expErr && !v.isWrite) begin
      checkOutput("rd_first_latency", firstRvCycle - hsCycle, 3);
      checkOutput("rd_done_latency", doneCycle - hsCycle, int'(v.len) + 4);
    end
  endtask

  initial begin
    int pat[4] = '{1, 0, 0, 1};
    int bad;
    for (int i = 0; i < 16; i++) begin
      ram[i] = 8'h00;
      shadow[i] = 8'h00;
    end
    mem_rdata = 8'h00;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    wr_valid = 0; wr_data = 0; rd_ready = 0;
    clearLog();

    vecs[0] = '{1'b1, 4'd0,  4'd15, 8'h01, 1'b0, 16, 1};
    vecs[1] = '{1'b1, 4'd4,  4'd3,  8'h11, 1'b0, 4,  1};
    vecs[2] = '{1'b0, 4'd4,  4'd3,  8'h00, 1'b0, 4,  1};
    vecs[3] = '{1'b1, 4'd0,  4'd0,  8'hA5, 1'b0, 1,  1};
    vecs[4] = '{1'b0, 4'd0,  4'd0,  8'h00, 1'b0, 1,  1};
    vecs[5] = '{1'b1, 4'd15, 4'd0,  8'h5A, 1'b0, 1,  1};
    vecs[6] = '{1'b0, 4'd15, 4'd0,  8'h00, 1'b0, 1,  1};
    vecs[7] = '{1'b1, 4'd14, 4'd3,  8'h60, !WRAP, WRAP ? 4 : 0, WRAP ? 1 : 0};
    vecs[8] = '{1'b0, 4'd14, 4'd3,  8'h00, !WRAP, WRAP ? 4 : 0, WRAP ? 1 : 0};
    vecs[9] = '{1'b0, 4'd0,  4'd15, 8'h00, 1'b0, 16, 1};

    // Reset state.
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_cmd_ready", int'(cmd_ready), 1);
    checkOutput("rst_quiet_outs", int'({wr_ready, rd_valid, done, err, mem_wen, mem_ren}), 0);
    checkOutput("rst_data_outs", int'({mem_addr, mem_wdata, rd_data}), 0);
    rst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) runVector(i);

    // Read burst of 8 beats with rd_ready cycling 1,0,0,1.
    clearLog();
    sendCmd(1'b0, 4'd0, 4'd7);
    for (int i = 0; i < 100 && doneCount == 0; i++) begin
      rd_ready = pat[i % 4][0];
      @(posedge clk); #1;
    end
    rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bad = 0;
    for (int i = 0; i < rdOut.size(); i++) if (rdOut[i] !== shadow[i]) bad++;
    checkOutput("throttle_beats", rdOut.size(), 8);
    checkOutput("throttle_data_errors", bad, 0);
    checkOutput("throttle_max_outstanding_over2", int'(maxOut > 2), 0);
    checkOutput("throttle_done", doneCount, 1);
    checkOutput("throttle_ren_count", renAddr.size(), 8);

    // Write burst with wr_valid gaps.
    clearLog();
    sendCmd(1'b1, 4'd8, 4'd3);
    applyStimulus(3, 8'hC0, 16'b0000_0000_0011_0010);
    waitEnd("gap_end");
    bad = 0;
    for (int i = 0; i < wenAddr.size(); i++) begin
      if (wenAddr[i] !== 4'(8 + i) || wenData[i] !== beatData(8'hC0, i)) bad++;
      shadow[8 + i] = beatData(8'hC0, i);
    end
    checkOutput("gap_wen_count", wenAddr.size(), 4);
    checkOutput("gap_seq_errors", bad, 0);
    checkOutput("gap_done", doneCount, 1);

    // Reset in the middle of a stalled read with two beats buffered.
    clearLog();
    rd_ready = 1'b0;
    sendCmd(1'b0, 4'd0, 4'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    checkOutput("pre_rst_rd_valid", int'(rd_valid), 1);
    checkOutput("pre_rst_stalled_ren", int'(mem_ren), 0);
    checkOutput("pre_rst_outstanding", issued - popped, 2);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_rd_valid", int'(rd_valid), 0);
    checkOutput("mid_rst_ren", int'(mem_ren), 0);
    checkOutput("mid_rst_done", int'(done), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("post_rst_cmd_ready", int'(cmd_ready), 1);
    checkOutput("post_rst_rd_valid", int'(rd_valid), 0);
    checkOutput("post_rst_no_done", doneCount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
